wb_stage: RTL
=============

# wb_stage

Parametrised, registered write-back stage for the pipelined core. It accepts one retiring instruction per cycle from MEM and formats load data: byte/half/word selection by address offset, with sign or zero extension. It waits in a stall state when load data returns late from data memory, and drives registered integer and FP register-file write ports.

## Interface
Parameters:
- DATA_W, 32: datapath width; a multiple of 16 and at least 32.
- REG_AW, 5: register address width.
- TIMEOUT, 64: cycles a load may wait for data before the error flag is set.

Ports:
- clk, in, 1: the single clock; all state changes on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: MEM presents an instruction.
- in_ready, out, 1: stage can accept; a transfer occurs when in_valid && in_ready.
- is_load, in, 1: the instruction writes memory data rather than the ALU result.
- size, in, 2: 00 = byte, 01 = half, 10 = word; 11 is illegal.
- is_unsigned, in, 1: zero-extend instead of sign-extend.
- addr_lo, in, $clog2(DATA_W/8): byte offset of the load address.
- alu_result, in, DATA_W: value for non-load writes.
- wr_reg, in, REG_AW: destination register.
- reg_wen, in, 1: integer register write requested.
- fp_wen, in, 1: FP register write requested.
- mem_rvalid, in, 1: mem_rdata is valid this cycle.
- mem_rdata, in, DATA_W: load data word.
- rf_we, out, 1: integer register-file write enable.
- fp_we, out, 1: FP register-file write enable.
- rf_waddr, out, REG_AW: write address.
- rf_wdata, out, DATA_W: write data.
- err_misalign, out, 1: sticky; half at odd offset, word at non-zero offset, or size 11.
- err_timeout, out, 1: sticky; load wait exceeded TIMEOUT.

## Operation
- FSM states: IDLE and WAIT_MEM.
- IDLE: in_ready = 1.
  - Transfer of a non-load, or of a load with mem_rvalid high in the same cycle: write registered next cycle; stay in IDLE.
  - Transfer of a load with mem_rvalid low: capture the instruction fields, go to WAIT_MEM.
- WAIT_MEM: in_ready = 0; the wait counter increments each cycle.
  - On mem_rvalid: format data, issue write next cycle, clear the counter, return to IDLE.
  - mem_rvalid while in IDLE with no load transfer is ignored.
- Byte lanes are big-endian: offset 0 selects bits DATA_W-1..DATA_W-8.
  - Half-word offset k selects the 16 bits starting at byte k.
- Extension: sign-extend from the selected field's MSB unless is_unsigned; word loads pass through unchanged.
- rf_we = reg_wen && wr_reg != 0. Integer writes to register 0 are suppressed; fp_we is unaffected by wr_reg.
- Misaligned or illegal-size load:
  - set err_misalign;
  - suppress both write enables for that instruction;
  - no WAIT_MEM entry; a pending mem_rvalid is not awaited.
- err flags clear only on rst.

## Timing
- Reset: in_ready = 1, rf_we = 0, fp_we = 0, rf_waddr = 0, rf_wdata = 0, err flags = 0, state = IDLE, counter = 0.
- Reset asserted mid-WAIT_MEM: the pending load is discarded; no write is issued.
- Latency: 1 cycle from the transfer edge, or from the mem_rvalid edge for late loads.
- Write enables are single-cycle pulses. rf_waddr and rf_wdata hold their last value while the enables are low.
- Throughput: one per cycle in IDLE; no new transfer while in WAIT_MEM.
- Timeout:
  - err_timeout sets on the cycle the counter reaches TIMEOUT;
  - the stage keeps waiting and completes normally if data later arrives;
  - the counter saturates at TIMEOUT.

## Configuration
- WB_TIMEOUT_EN defined: wait counter and err_timeout logic present.
- WB_TIMEOUT_EN not defined: no counter; err_timeout is tied to 0; WAIT_MEM waits indefinitely.

## Structure
- Package wb_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state enum WB_IDLE, WB_WAIT_MEM;
  - function for the alignment check.
- Sub-module wb_load_fmt: combinational lane select and extension; inputs rdata, size, addr_lo, is_unsigned; output DATA_W result.

## Test plan
- Non-load: alu_result = 0x12345678, wr_reg = 3, reg_wen = 1 -> next cycle rf_we = 1, rf_waddr = 3, rf_wdata = 0x12345678.
- Signed byte load, offset 1, mem_rdata = 0x00F00000 in the transfer cycle -> rf_wdata = 0xFFFFFFF0. With is_unsigned -> 0x000000F0.
- Half load, offset 2, mem_rdata = 0x00008001, mem_rvalid 3 cycles late:
  - in_ready low for 3 cycles;
  - rf_wdata = 0xFFFF8001 the cycle after rvalid.
- Write to wr_reg = 0 with reg_wen = 1, fp_wen = 1 -> rf_we = 0, fp_we = 1.
- Word load at offset 2 -> err_misalign = 1, no write, in_ready stays 1.
- WB_TIMEOUT_EN with TIMEOUT = 4 and no rvalid for 6 cycles -> err_timeout = 1 at the 4th wait cycle. A later rvalid completes the write. Then assert rst -> all outputs return to reset values.

Source files
------------

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg -- shared definitions for the write-back stage.
//
// Contents:
//   SZ_BYTE / SZ_HALF / SZ_WORD : load size encodings (2'b11 is illegal)
//   wb_state_e                  : write-back FSM states (WB_IDLE, WB_WAIT_MEM)
//   wb_misaligned()             : alignment / legality check for a load
//
// Optional feature macro used by wb_stage: WB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_e;

    // The byte offset is passed zero-extended to 8 bits so the function does
    // not depend on DATA_W. A "word" is the full datapath width, so it must
    // sit at offset 0; halves must sit on an even byte.
    function automatic logic wb_misaligned(input logic [1:0] sz,
                                           input logic [7:0] off);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 8'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/wb_load_fmt.sv
// -----------------------------------------------------------------------------
// wb_load_fmt -- combinational load-data formatter.
//
// Selects a byte, half-word or full word from the returned memory word and
// sign- or zero-extends it to DATA_W. Byte lanes are big-endian: offset 0 is
// bits DATA_W-1..DATA_W-8.
//
// Ports:
//   rdata       in  DATA_W           raw load data word
//   size        in  2                SZ_BYTE / SZ_HALF / SZ_WORD
//   addr_lo     in  $clog2(DATA_W/8) byte offset
//   is_unsigned in  1                zero-extend instead of sign-extend
//   result      out DATA_W           formatted write-back value
// -----------------------------------------------------------------------------
module wb_load_fmt #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]             rdata,
    input  logic [1:0]                    size,
    input  logic [$clog2(DATA_W/8)-1:0]   addr_lo,
    input  logic                          is_unsigned,
    output logic [DATA_W-1:0]             result
);
    import wb_pkg::*;

    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(NB);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane muxes built from constant slices. Odd half offsets are misaligned
    // and never written back, so they simply select zero.
    always_comb begin
        byte_sel = '0;
        half_sel = '0;
        for (int i = 0; i < NB; i++) begin
            if (addr_lo == AW'(i)) byte_sel = rdata[DATA_W-1-8*i -: 8];
        end
        for (int i = 0; i < NB - 1; i += 2) begin
            if (addr_lo == AW'(i)) half_sel = rdata[DATA_W-1-8*i -: 16];
        end
    end

    always_comb begin
        result = rdata;
        case (size)
            SZ_BYTE: result = {{(DATA_W-8){~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_HALF: result = {{(DATA_W-16){~is_unsigned & half_sel[15]}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- registered write-back stage.
//
// Accepts one retiring instruction per cycle from MEM, formats load data and
// drives registered integer / FP register-file write ports. A load whose data
// is not back in the transfer cycle parks the stage in WB_WAIT_MEM until
// mem_rvalid arrives.
//
// Parameters: DATA_W (multiple of 16, >= 32), REG_AW, TIMEOUT.
// Configuration macro: WB_TIMEOUT_EN -- when defined, a wait counter raises
// the sticky err_timeout after TIMEOUT cycles in WB_WAIT_MEM; otherwise
// err_timeout is tied low and the wait is unbounded.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      MEM handshake (transfer when both high)
//   is_load, size,
//   is_unsigned, addr_lo     load descriptor
//   alu_result               value for non-load writes
//   wr_reg, reg_wen, fp_wen  destination and requested write enables
//   mem_rvalid, mem_rdata    load data return
//   rf_we, fp_we             single-cycle write-enable pulses
//   rf_waddr, rf_wdata       write address / data (held while enables low)
//   err_misalign             sticky misaligned / illegal-size load flag
//   err_timeout              sticky load-wait timeout flag
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          is_load,
    input  logic [1:0]                    size,
    input  logic                          is_unsigned,
    input  logic [$clog2(DATA_W/8)-1:0]   addr_lo,
    input  logic [DATA_W-1:0]             alu_result,
    input  logic [REG_AW-1:0]             wr_reg,
    input  logic                          reg_wen,
    input  logic                          fp_wen,
    input  logic                          mem_rvalid,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          rf_we,
    output logic                          fp_we,
    output logic [REG_AW-1:0]             rf_waddr,
    output logic [DATA_W-1:0]             rf_wdata,
    output logic                          err_misalign,
    output logic                          err_timeout
);
    import wb_pkg::*;

    localparam int AW = $clog2(DATA_W/8);

    // Instruction fields needed to finish a load after a late data return.
    typedef struct packed {
        logic [1:0]        size;
        logic              is_unsigned;
        logic [AW-1:0]     addr_lo;
        logic [REG_AW-1:0] wr_reg;
        logic              reg_wen;
        logic              fp_wen;
    } ld_ctx_t;

    wb_state_e         state_q, state_d;
    ld_ctx_t           ctx_live, ctx_sel, ctx_q, ctx_d;

    logic              xfer;
    logic              misal;
    logic              issue;
    logic              use_fmt;
    logic [DATA_W-1:0] fmt_data;

    logic              rf_we_q, rf_we_d;
    logic              fp_we_q, fp_we_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_mis_q, err_mis_d;

    // -------------------------------------------------------------------------
    // Handshake and decode
    // -------------------------------------------------------------------------
    assign xfer  = in_valid && (state_q == WB_IDLE);
    assign misal = is_load && wb_misaligned(size, 8'(addr_lo));

    always_comb begin
        ctx_live.size        = size;
        ctx_live.is_unsigned = is_unsigned;
        ctx_live.addr_lo     = addr_lo;
        ctx_live.wr_reg      = wr_reg;
        ctx_live.reg_wen     = reg_wen;
        ctx_live.fp_wen      = fp_wen;
    end

    // Fields are captured on every transfer; they are only consumed when the
    // transfer sent the FSM into WB_WAIT_MEM.
    assign ctx_d = xfer ? ctx_live : ctx_q;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= WB_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE:     if (xfer && is_load && !misal && !mem_rvalid) state_d = WB_WAIT_MEM;
            WB_WAIT_MEM: if (mem_rvalid) state_d = WB_IDLE;
            default:     state_d = WB_IDLE;
        endcase
    end

    // FSM: outputs. In IDLE the live inputs drive the write; in WAIT_MEM the
    // captured context is used and stray input traffic is ignored.
    always_comb begin
        in_ready = 1'b0;
        issue    = 1'b0;
        ctx_sel  = ctx_live;
        use_fmt  = is_load;
        case (state_q)
            WB_IDLE: begin
                in_ready = 1'b1;
                issue    = in_valid && (!is_load || (!misal && mem_rvalid));
                ctx_sel  = ctx_live;
                use_fmt  = is_load;
            end
            WB_WAIT_MEM: begin
                issue    = mem_rvalid;
                ctx_sel  = ctx_q;
                use_fmt  = 1'b1;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Load formatting (single instance shared by both paths)
    // -------------------------------------------------------------------------
    wb_load_fmt #(.DATA_W(DATA_W)) u_fmt (
        .rdata       (mem_rdata),
        .size        (ctx_sel.size),
        .addr_lo     (ctx_sel.addr_lo),
        .is_unsigned (ctx_sel.is_unsigned),
        .result      (fmt_data)
    );

    // -------------------------------------------------------------------------
    // Write-port next state. Register 0 is hard-wired on the integer side
    // only. Address and data update only when a write actually goes out.
    // -------------------------------------------------------------------------
    always_comb begin
        rf_we_d   = issue && ctx_sel.reg_wen && (ctx_sel.wr_reg != '0);
        fp_we_d   = issue && ctx_sel.fp_wen;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        if (rf_we_d || fp_we_d) begin
            waddr_d = ctx_sel.wr_reg;
            wdata_d = use_fmt ? fmt_data : alu_result;
        end
        err_mis_d = err_mis_q | (xfer && misal);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctx_q     <= '0;
            rf_we_q   <= 1'b0;
            fp_we_q   <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            err_mis_q <= 1'b0;
        end else begin
            ctx_q     <= ctx_d;
            rf_we_q   <= rf_we_d;
            fp_we_q   <= fp_we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            err_mis_q <= err_mis_d;
        end
    end

    assign rf_we        = rf_we_q;
    assign fp_we        = fp_we_q;
    assign rf_waddr     = waddr_q;
    assign rf_wdata     = wdata_q;
    assign err_misalign = err_mis_q;

    // -------------------------------------------------------------------------
    // Load-wait timeout
    // -------------------------------------------------------------------------
`ifdef WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_to_q, err_to_d;

    // Counter advances once per waiting cycle, saturates at TIMEOUT and is
    // cleared when the data arrives. The flag rises on the same edge the
    // counter reaches TIMEOUT.
    always_comb begin
        cnt_d    = cnt_q;
        err_to_d = err_to_q;
        if (state_q == WB_WAIT_MEM) begin
            if (mem_rvalid)                 cnt_d = '0;
            else if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == CW'(TIMEOUT)) err_to_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            err_to_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            err_to_q <= err_to_d;
        end
    end

    assign err_timeout = err_to_q;
`else
    // TIMEOUT has no effect in this build; the wait is unbounded.
    logic unused_cfg;
    assign unused_cfg  = (TIMEOUT > 0);
    assign err_timeout = 1'b0;
`endif

endmodule
